// File: rtl/cache_ctrl_fsm.sv
// Cache command controller: accepts GET/PUT/DEL requests, dispatches them to the
// matching sub-FSM, guards each operation with a timeout and returns one response.

package ctrl_types_pkg;
    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;
endpackage

module cache_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [1:0]                resp_status,
    output logic [1:0]                resp_op,
    output logic                      busy,
    output logic                      get_en,
    output logic                      put_en,
    output logic                      del_en,
    output logic                      get_enter,
    output logic                      put_enter,
    output logic                      del_enter,
    input  ctrl_types_pkg::sub_cmd_t  get_cmd,
    input  ctrl_types_pkg::sub_cmd_t  put_cmd,
    input  ctrl_types_pkg::sub_cmd_t  del_cmd
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OP_GET = 3'd1,
        OP_PUT = 3'd2,
        OP_DEL = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [1:0]                status_q, status_d;
    logic [7:0]                timer_q, timer_d;
    logic                      first_q, first_d;
    logic                      in_op;
    ctrl_types_pkg::sub_cmd_t  sel_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            status_q <= '0;
            timer_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            status_q <= status_d;
            timer_q  <= timer_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        status_d    = status_q;
        timer_d     = timer_q;
        first_d     = first_q;
        in_op       = 1'b0;
        sel_cmd     = '0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_status = '0;
        resp_op     = '0;
        busy        = (state_q != IDLE);
        get_en      = 1'b0;
        put_en      = 1'b0;
        del_en      = 1'b0;
        get_enter   = 1'b0;
        put_enter   = 1'b0;
        del_enter   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    timer_d = '0;
                    first_d = 1'b1;
                    case (req_op)
                        2'b01:   state_d = OP_GET;
                        2'b10:   state_d = OP_PUT;
                        2'b11:   state_d = OP_DEL;
                        default: begin
                            state_d  = RESP;
                            status_d = ST_ILLEGAL;
                            first_d  = 1'b0;
                        end
                    endcase
                end
            end
            OP_GET: begin
                in_op     = 1'b1;
                get_en    = 1'b1;
                get_enter = first_q;
                sel_cmd   = get_cmd;
            end
            OP_PUT: begin
                in_op     = 1'b1;
                put_en    = 1'b1;
                put_enter = first_q;
                sel_cmd   = put_cmd;
            end
            OP_DEL: begin
                in_op     = 1'b1;
                del_en    = 1'b1;
                del_enter = first_q;
                sel_cmd   = del_cmd;
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_status = status_q;
                resp_op     = op_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sub-FSM status is stale during the enter cycle, so nothing is sampled then.
        if (in_op) begin
            timer_d = timer_q + 8'd1;
            first_d = 1'b0;
            if (!first_q) begin
                if (sel_cmd.error) begin
                    state_d  = RESP;
                    status_d = ST_ERROR;
                end else if (sel_cmd.done) begin
                    state_d  = RESP;
                    status_d = ST_OK;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = RESP;
                    status_d = ST_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with hand-computed expectations.

module tb_cache_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_ready;
    logic [1:0] req_op;
    logic resp_valid;
    logic resp_ready;
    logic [1:0] resp_status;
    logic [1:0] resp_op;
    logic busy;
    logic get_en, put_en, del_en;
    logic get_enter, put_enter, del_enter;
    ctrl_types_pkg::sub_cmd_t get_cmd, put_cmd, del_cmd;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cache_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_op     (resp_op),
        .busy        (busy),
        .get_en      (get_en),
        .put_en      (put_en),
        .del_en      (del_en),
        .get_enter   (get_enter),
        .put_enter   (put_enter),
        .del_enter   (del_enter),
        .get_cmd     (get_cmd),
        .put_cmd     (put_cmd),
        .del_cmd     (del_cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {get_en, put_en, del_en, get_enter, put_enter, del_enter};
    endfunction

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_after_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_after_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cnt;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        resp_ready = 1'b0;
        get_cmd    = '0;
        put_cmd    = '0;
        del_cmd    = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_strobes", strobes(), 6'b0);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", req_ready, 1'b1);

        // DEL hit
        req_valid = 1'b1; req_op = 2'b11;
        tick();
        req_valid = 1'b0;
        check("del_enter_cycle", strobes(), 6'b001001);
        check("del_busy", busy, 1'b1);
        check("del_req_ready", req_ready, 1'b0);
        del_cmd.done = 1'b1;
        tick();
        check("del_status_cycle", strobes(), 6'b001000);
        check("del_no_resp_yet", resp_valid, 1'b0);
        tick();
        del_cmd = '0;
        check("del_resp_valid", resp_valid, 1'b1);
        check("del_resp_status", resp_status, 2'b00);
        check("del_resp_op", resp_op, 2'b11);
        check("del_resp_strobes", strobes(), 6'b0);
        handshake("del");

        // GET with simultaneous error and done
        req_valid = 1'b1; req_op = 2'b01;
        tick();
        req_valid = 1'b0;
        check("get_enter_cycle", strobes(), 6'b100100);
        tick();
        get_cmd.error = 1'b1; get_cmd.done = 1'b1;
        tick();
        get_cmd = '0;
        check("get_resp_valid", resp_valid, 1'b1);
        check("get_resp_status", resp_status, 2'b01);
        check("get_resp_op", resp_op, 2'b01);
        handshake("get");

        // PUT timeout, done pulse only in the enter cycle
        req_valid = 1'b1; req_op = 2'b10;
        tick();
        req_valid = 1'b0;
        check("put_enter_strobe", put_enter, 1'b1);
        put_cmd.done = 1'b1;
        cnt = 0;
        while (put_en && cnt < 40) begin
            cnt++;
            tick();
            put_cmd = '0;
        end
        check("put_en_cycles", cnt, 32'd16);
        check("put_resp_valid", resp_valid, 1'b1);
        check("put_resp_status", resp_status, 2'b10);
        check("put_resp_op", resp_op, 2'b10);
        handshake("put");

        // Illegal op with backpressure
        req_valid = 1'b1; req_op = 2'b00;
        tick();
        req_valid = 1'b0;
        check("ill_resp_valid", resp_valid, 1'b1);
        check("ill_resp_status", resp_status, 2'b11);
        check("ill_resp_op", resp_op, 2'b00);
        check("ill_strobes", strobes(), 6'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ill_bp_valid", resp_valid, 1'b1);
            check("ill_bp_status", resp_status, 2'b11);
            check("ill_bp_req_ready", req_ready, 1'b0);
            check("ill_bp_strobes", strobes(), 6'b0);
        end
        handshake("ill");
        check("ill_idle_busy", busy, 1'b0);

        // Back-to-back GET then DEL with req_valid held
        req_valid = 1'b1; req_op = 2'b01;
        tick();
        req_op = 2'b11;
        check("b2b_get_enter", strobes(), 6'b100100);
        get_cmd.done = 1'b1;
        tick();
        check("b2b_get_enter_width", strobes(), 6'b100000);
        tick();
        get_cmd = '0;
        check("b2b_get_resp_status", resp_status, 2'b00);
        check("b2b_resp_req_ready", req_ready, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("b2b_idle_req_ready", req_ready, 1'b1);
        check("b2b_idle_strobes", strobes(), 6'b0);
        tick();
        req_valid = 1'b0;
        check("b2b_del_enter", strobes(), 6'b001001);
        del_cmd.done = 1'b1;
        tick();
        check("b2b_del_enter_width", strobes(), 6'b001000);
        tick();
        del_cmd = '0;
        check("b2b_del_resp_op", resp_op, 2'b11);
        check("b2b_del_resp_status", resp_status, 2'b00);
        handshake("b2b");

        // Reset during OP_PUT cycle 4
        req_valid = 1'b1; req_op = 2'b10;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        check("rmid_put_en_before", put_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_put_en", put_en, 1'b0);
        check("rmid_busy", busy, 1'b0);
        check("rmid_resp_valid", resp_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rmid_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_op = 2'b11;
        tick();
        req_valid = 1'b0;
        check("rmid_del_enter", strobes(), 6'b001001);
        del_cmd.done = 1'b1;
        tick();
        tick();
        del_cmd = '0;
        check("rmid_del_resp_valid", resp_valid, 1'b1);
        check("rmid_del_resp_status", resp_status, 2'b00);
        handshake("rmid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
